// File: rtl/reg_access_arbiter.sv
// reg_access_arbiter: round-robin arbiter of three masters onto one register-file port; REG_ARB_TIMEOUT_EN adds a reg_ack timeout
module reg_access_arbiter #(
  parameter int data_witdh  = 32,
  parameter int addr_witdh  = 5,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [2:0]              m_req,
  input  logic [2:0]              m_rw,
  input  logic [3*addr_witdh-1:0] m_addr,
  input  logic [3*data_witdh-1:0] m_wdata,
  output logic [2:0]              m_ack,
  output logic [2:0]              m_err,
  output logic [data_witdh-1:0]   m_rdata,
  output logic [2:0]              grant,
  output logic                    reg_req,
  output logic                    reg_rw,
  output logic [addr_witdh-1:0]   reg_addr,
  output logic [data_witdh-1:0]   reg_wdata,
  input  logic                    reg_ack,
  input  logic [data_witdh-1:0]   reg_rdata
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, DONE} state_t;
  state_t state_q, state_d;
  logic [1:0] ptr_q, ptr_d, c1, c2, win;
  logic [2:0] grant_q, grant_d, m_ack_q, m_ack_d;
  logic [data_witdh-1:0] m_rdata_q, m_rdata_d, reg_wdata_q, reg_wdata_d;
  logic [addr_witdh-1:0] reg_addr_q, reg_addr_d;
  logic reg_req_q, reg_req_d, reg_rw_q, reg_rw_d;
`ifdef REG_ARB_TIMEOUT_EN
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] m_err_q, m_err_d;
  logic tmo;
  assign tmo = cnt_q == 8'(ACK_TIMEOUT - 1);
  assign m_err = m_err_q;
`else
  assign m_err = '0;
`endif
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 255) begin : g_bad_timeout
    $error("ACK_TIMEOUT must be in 1..255");
  end
  // ptr_q holds the last winner; search starts at the next requester and wraps back to it
  assign c1  = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;
  assign c2  = (c1 == 2'd2) ? 2'd0 : c1 + 2'd1;
  assign win = m_req[c1] ? c1 : m_req[c2] ? c2 : ptr_q;
  // next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    m_ack_d     = '0;
    m_rdata_d   = m_rdata_q;
    reg_req_d   = reg_req_q;
    reg_rw_d    = reg_rw_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
`ifdef REG_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    m_err_d = '0;
`endif
    case (state_q)
      IDLE: if (|m_req) begin
        state_d     = WAIT_ACK;
        ptr_d       = win;
        grant_d     = 3'b001 << win;
        reg_req_d   = 1'b1;
        reg_rw_d    = m_rw[win];
        reg_addr_d  = m_addr[win*addr_witdh +: addr_witdh];
        reg_wdata_d = m_wdata[win*data_witdh +: data_witdh];
`ifdef REG_ARB_TIMEOUT_EN
        cnt_d = '0;
`endif
      end
      WAIT_ACK: if (reg_ack) begin
        state_d   = DONE;
        reg_req_d = 1'b0;
        m_ack_d   = grant_q;
        m_rdata_d = reg_rw_q ? reg_rdata : '0;
      end
`ifdef REG_ARB_TIMEOUT_EN
      else if (tmo) begin
        state_d   = DONE;
        reg_req_d = 1'b0;
        m_ack_d   = grant_q;
        m_err_d   = grant_q;
        m_rdata_d = '0;
      end else cnt_d = cnt_q + 8'd1;
`endif
      DONE: if (!reg_ack) begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and output registers; reset leaves CPU (bit0) next in line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd2;
      grant_q     <= '0;
      m_ack_q     <= '0;
      m_rdata_q   <= '0;
      reg_req_q   <= 1'b0;
      reg_rw_q    <= 1'b0;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
`ifdef REG_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      m_err_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      m_ack_q     <= m_ack_d;
      m_rdata_q   <= m_rdata_d;
      reg_req_q   <= reg_req_d;
      reg_rw_q    <= reg_rw_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
`ifdef REG_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      m_err_q <= m_err_d;
`endif
    end
  end
  assign grant     = grant_q;
  assign m_ack     = m_ack_q;
  assign m_rdata   = m_rdata_q;
  assign reg_req   = reg_req_q;
  assign reg_rw    = reg_rw_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
endmodule

// File: tb/tb_reg_access_arbiter.sv
// tb_reg_access_arbiter: vector table, hand-written corner sequences and randomized round-robin model check
module tb_reg_access_arbiter;
  localparam int DW = 32;
  localparam int AW = 5;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] m_req = '0, m_rw = '0;
  logic [3*AW-1:0] m_addr = '0;
  logic [3*DW-1:0] m_wdata = '0;
  logic [2:0] m_ack, m_err, grant;
  logic [DW-1:0] m_rdata, reg_wdata, reg_rdata;
  logic [AW-1:0] reg_addr;
  logic reg_req, reg_rw, reg_ack;
  logic ack_auto = 1'b0, ack_man = 1'b0, use_fn = 1'b0;
  logic [31:0] rdata_man = '0;
  int rf_mode = 0;
  int n_chk = 0, n_pass = 0;
  typedef struct {
    logic [2:0]  req;
    logic        rw;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [2:0]  exp_grant;
  } vec_t;
  vec_t tbl[7];
  always #5 clk = ~clk;
  reg_access_arbiter dut (
    .clk(clk), .reset(reset), .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_err(m_err), .m_rdata(m_rdata), .grant(grant), .reg_req(reg_req),
    .reg_rw(reg_rw), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ack(reg_ack), .reg_rdata(reg_rdata)
  );
  function automatic logic [31:0] rf_fn(input logic [4:0] a);
    return 32'h9E37_79B9 * (32'(a) + 32'd1);
  endfunction
  assign reg_rdata = use_fn ? rf_fn(reg_addr) : rdata_man;
  assign reg_ack   = (rf_mode == 2) ? ack_man : ack_auto;
  // register file: mode 0 acks one cycle after seeing reg_req, mode 1 adds random stalls
  always @(posedge clk)
    ack_auto <= (rf_mode == 1) ? (reg_req && (ack_auto || $urandom_range(0, 2) != 0)) : reg_req;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask
  task automatic drive_vec(input vec_t v, input int w);
    for (int i = 0; i < 3; i++) begin
      m_addr[i*AW +: AW]  = (i == w) ? v.addr : ~v.addr;
      m_wdata[i*DW +: DW] = (i == w) ? v.wdata : ~v.wdata;
      m_rw[i]             = (i == w) ? v.rw : ~v.rw;
    end
    m_req = v.req;
  endtask
  task automatic run_vec(input vec_t v);
    int w;
    w = v.exp_grant[0] ? 0 : v.exp_grant[1] ? 1 : 2;
    rdata_man = v.rdata;
    drive_vec(v, w);
    @(negedge clk);
    chk("vec_grant", 32'(grant), 32'(v.exp_grant));
    chk("vec_reg_req", 32'(reg_req), 32'd1);
    chk("vec_reg_rw", 32'(reg_rw), 32'(v.rw));
    chk("vec_reg_addr", 32'(reg_addr), 32'(v.addr));
    chk("vec_reg_wdata", reg_wdata, v.wdata);
    m_req = '0;
    @(negedge clk);
    chk("vec_ack_early", 32'(m_ack), 32'd0);
    chk("vec_req_held", 32'(reg_req), 32'd1);
    chk("vec_addr_held", 32'(reg_addr), 32'(v.addr));
    @(negedge clk);
    chk("vec_ack", 32'(m_ack), 32'(v.exp_grant));
    chk("vec_rdata", m_rdata, v.rw ? v.rdata : 32'd0);
    chk("vec_err", 32'(m_err), 32'd0);
    chk("vec_req_fall", 32'(reg_req), 32'd0);
    @(negedge clk);
    chk("vec_ack_pulse", 32'(m_ack), 32'd0);
    chk("vec_grant_done", 32'(grant), 32'(v.exp_grant));
    @(negedge clk);
    chk("vec_grant_idle", 32'(grant), 32'd0);
  endtask
  initial begin
    logic [2:0] rr_exp[6];
    logic [2:0] p_req, p_rw, p_grant;
    logic [3*AW-1:0] p_addr;
    logic [3*DW-1:0] p_wdata;
    logic [4:0] t_addr;
    logic [31:0] t_wdata;
    logic t_rw, seen;
    int n, last, pk, j, t_idx, acks, n_txn;
    int waits[3];
    vec_t hv;
    tbl[0] = '{3'b001, 1'b1, 5'h03, 32'h0000_0000, 32'h1234_0040, 3'b001};
    tbl[1] = '{3'b010, 1'b0, 5'h02, 32'hDEAD_BEEF, 32'h1111_2222, 3'b010};
    tbl[2] = '{3'b111, 1'b1, 5'h1F, 32'h0BAD_F00D, 32'h0000_0007, 3'b100};
    tbl[3] = '{3'b101, 1'b0, 5'h00, 32'h0000_0000, 32'hFFFF_0000, 3'b001};
    tbl[4] = '{3'b101, 1'b1, 5'h11, 32'h7777_7777, 32'hFFFF_FFFF, 3'b100};
    tbl[5] = '{3'b110, 1'b1, 5'h15, 32'h0000_0001, 32'hA5A5_5A5A, 3'b010};
    tbl[6] = '{3'b011, 1'b0, 5'h0C, 32'h1357_9BDF, 32'h2468_ACE0, 3'b001};
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_ack", 32'(m_ack), 32'd0);
    chk("rst_err", 32'(m_err), 32'd0);
    chk("rst_rdata", m_rdata, 32'd0);
    chk("rst_reg_req", 32'(reg_req), 32'd0);
    chk("rst_reg_rw", 32'(reg_rw), 32'd0);
    chk("rst_reg_addr", 32'(reg_addr), 32'd0);
    chk("rst_reg_wdata", reg_wdata, 32'd0);
    reset = 1'b0;
    for (int t = 0; t < 7; t++) run_vec(tbl[t]);
    // wait for a winner that still requests after DONE, with reg_ack held high
    rf_mode = 2;
    ack_man = 1'b0;
    hv = '{3'b100, 1'b0, 5'h07, 32'h0000_0055, 32'h0, 3'b100};
    drive_vec(hv, 2);
    @(negedge clk);
    chk("hold_grant", 32'(grant), 32'b100);
    ack_man = 1'b1;
    @(negedge clk);
    chk("hold_ack", 32'(m_ack), 32'b100);
    chk("hold_req_fall", 32'(reg_req), 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("hold_no_req", 32'(reg_req), 32'd0);
      chk("hold_in_done", 32'(grant), 32'b100);
    end
    ack_man = 1'b0;
    @(negedge clk);
    chk("hold_idle_grant", 32'(grant), 32'd0);
    chk("hold_idle_req", 32'(reg_req), 32'd0);
    @(negedge clk);
    chk("hold_rereq", 32'(reg_req), 32'd1);
    chk("hold_regrant", 32'(grant), 32'b100);
    m_req = '0;
    ack_man = 1'b1;
    @(negedge clk);
    chk("hold_ack2", 32'(m_ack), 32'b100);
    ack_man = 1'b0;
    @(negedge clk);
    chk("hold_end", 32'(grant), 32'd0);
    // asynchronous reset in WAIT_ACK, then pointer back to CPU
    hv = '{3'b001, 1'b1, 5'h1A, 32'hCAFE_0001, 32'h0, 3'b001};
    drive_vec(hv, 0);
    @(negedge clk);
    chk("ar_grant", 32'(grant), 32'b001);
    m_req = '0;
    #2 reset = 1'b1;
    #1;
    chk("ar_grant0", 32'(grant), 32'd0);
    chk("ar_req0", 32'(reg_req), 32'd0);
    chk("ar_rw0", 32'(reg_rw), 32'd0);
    chk("ar_addr0", 32'(reg_addr), 32'd0);
    chk("ar_wdata0", reg_wdata, 32'd0);
    chk("ar_ack0", 32'(m_ack), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("ar_no_ack", 32'(m_ack), 32'd0);
    chk("ar_idle", 32'(grant), 32'd0);
    hv = '{3'b101, 1'b1, 5'h09, 32'h0, 32'h0, 3'b001};
    drive_vec(hv, 0);
    @(negedge clk);
    chk("ar_cpu_first", 32'(grant), 32'b001);
    m_req = '0;
    ack_man = 1'b1;
    @(negedge clk);
    chk("ar_ack", 32'(m_ack), 32'b001);
    ack_man = 1'b0;
    @(negedge clk);
    chk("ar_end", 32'(grant), 32'd0);
    // reg_ack never arrives
    rdata_man = 32'hCAFE_F00D;
    hv = '{3'b010, 1'b1, 5'h04, 32'h0, 32'hCAFE_F00D, 3'b010};
    drive_vec(hv, 1);
    @(negedge clk);
    m_req = '0;
    seen = 1'b0;
`ifdef REG_ARB_TIMEOUT_EN
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      seen = seen | (|m_ack) | (|m_err);
    end
    chk("to_no_early_ack", 32'(seen), 32'd0);
    chk("to_req_held", 32'(reg_req), 32'd1);
    @(negedge clk);
    chk("to_ack", 32'(m_ack), 32'b010);
    chk("to_err", 32'(m_err), 32'b010);
    chk("to_rdata", m_rdata, 32'd0);
    chk("to_req_fall", 32'(reg_req), 32'd0);
    @(negedge clk);
    chk("to_ack_pulse", 32'(m_ack | m_err), 32'd0);
    chk("to_idle", 32'(grant), 32'd0);
`else
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      seen = seen | (|m_ack) | (|m_err);
    end
    chk("nto_no_ack", 32'(seen), 32'd0);
    chk("nto_req_held", 32'(reg_req), 32'd1);
    chk("nto_grant", 32'(grant), 32'b010);
    ack_man = 1'b1;
    @(negedge clk);
    chk("nto_ack", 32'(m_ack), 32'b010);
    chk("nto_rdata", m_rdata, 32'hCAFE_F00D);
    chk("nto_err", 32'(m_err), 32'd0);
    ack_man = 1'b0;
    @(negedge clk);
    chk("nto_idle", 32'(grant), 32'd0);
`endif
    // all three requesting continuously from reset
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rf_mode = 0;
    m_req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      while (grant == 3'd0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rr_grant", 32'(grant), 32'(rr_exp[k]));
      n = 0;
      while (grant != 3'd0 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("rr_release", 32'(grant), 32'd0);
    end
    m_req = '0;
    // randomized traffic against a transaction-level round-robin model
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    rf_mode = 1;
    use_fn = 1'b1;
    last = 2;
    t_idx = -1;
    acks = 0;
    n_txn = 0;
    waits = '{0, 0, 0};
    p_req = '0;
    p_rw = '0;
    p_addr = '0;
    p_wdata = '0;
    p_grant = '0;
    t_rw = 1'b0;
    t_addr = '0;
    t_wdata = '0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      @(negedge clk);
      chk("rnd_ack_onehot", 32'($onehot0(m_ack)), 32'd1);
      chk("rnd_ack_granted", 32'(m_ack & ~grant), 32'd0);
      chk("rnd_err", 32'(m_err), 32'd0);
      if (p_grant == 3'd0 && grant != 3'd0) begin
        if (t_idx >= 0) chk("rnd_ack_count", 32'(acks), 32'd1);
        pk = -1;
        for (int k = 1; k <= 3; k++) begin
          j = (last + k) % 3;
          if (pk < 0 && p_req[j]) pk = j;
        end
        chk("rnd_grant_had_req", 32'(p_req != 3'd0), 32'd1);
        if (pk >= 0) begin
          chk("rnd_grant", 32'(grant), 32'(3'b001 << pk));
          chk("rnd_reg_req", 32'(reg_req), 32'd1);
          chk("rnd_reg_rw", 32'(reg_rw), 32'(p_rw[pk]));
          chk("rnd_reg_addr", 32'(reg_addr), 32'(p_addr[pk*AW +: AW]));
          chk("rnd_reg_wdata", reg_wdata, p_wdata[pk*DW +: DW]);
          for (int i = 0; i < 3; i++) begin
            if (i == pk) waits[i] = 0;
            else if (p_req[i]) begin
              waits[i]++;
              chk("rnd_fair_wait", 32'(waits[i] <= 2), 32'd1);
            end else waits[i] = 0;
          end
          last = pk;
          t_idx = pk;
          t_rw = p_rw[pk];
          t_addr = p_addr[pk*AW +: AW];
          t_wdata = p_wdata[pk*DW +: DW];
          acks = 0;
          n_txn++;
        end
      end else if (grant != 3'd0 && reg_req) begin
        chk("rnd_stable", 32'({reg_rw, reg_addr} ^ {t_rw, t_addr}) | (reg_wdata ^ t_wdata), 32'd0);
      end
      if (m_ack != 3'd0) begin
        acks++;
        chk("rnd_ack_txn", 32'(t_idx >= 0), 32'd1);
        if (t_idx >= 0) begin
          chk("rnd_ack_owner", 32'(m_ack), 32'(3'b001 << t_idx));
          chk("rnd_rdata", m_rdata, t_rw ? rf_fn(t_addr) : 32'd0);
        end
      end
      p_grant = grant;
      for (int i = 0; i < 3; i++)
        m_req[i] = (cyc >= 1960) ? 1'b0 : m_req[i] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      m_rw = 3'($urandom);
      m_addr = 15'($urandom);
      m_wdata = {$urandom, $urandom, $urandom};
      p_req = m_req;
      p_rw = m_rw;
      p_addr = m_addr;
      p_wdata = m_wdata;
    end
    chk("rnd_last_ack", 32'(acks), 32'd1);
    chk("rnd_final_idle", 32'(grant), 32'd0);
    chk("rnd_activity", 32'(n_txn >= 50), 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
